imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_if.sv | 9 +
 rtl/imem_loader_byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;

    // States in which a frame is being received and the stream is open.
    function automatic logic is_active(input loader_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the instruction memory loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs consecutive bytes into a big-endian 32-bit word; word_valid marks the 4th byte.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int LANES = BYTES_PER_WORD - 1;

    logic [1:0] cnt_reg;
    logic [7:0] lane_reg [LANES];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_reg <= 2'd0;
            for (int i = 0; i < LANES; i++) lane_reg[i] <= 8'd0;
        end else if (byte_valid) begin
            cnt_reg <= cnt_reg + 2'd1;
            for (int i = 0; i < LANES - 1; i++) lane_reg[i] <= lane_reg[i + 1];
            lane_reg[LANES - 1] <= byte_data;
        end
    end

    // The oldest byte of the word sits in lane 0 and lands in the top byte.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign word[31 - 8 * gi -: 8] = lane_reg[gi];
        end
    endgenerate

    assign word[7:0]  = byte_data;
    assign word_valid = byte_valid && (cnt_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> instruction RAM writes, CPU held in reset until loaded.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int MEM_DEPTH = 1024,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      bs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] DEPTH_LIMIT = 17'(MEM_DEPTH);

    loader_state_t     state_reg, state_next;
    logic [7:0]        len_hi_reg;
    logic [15:0]       len_reg;
    logic [15:0]       word_idx_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;

    logic        accept;
    logic        start_load;
    logic        byte_valid;
    logic        word_valid;
    logic [31:0] packed_word;
    logic [15:0] len_full;
    logic        last_word;

    assign accept     = bs.in_valid && bs.in_ready;
    assign start_load = start && (state_reg == IDLE || state_reg == DONE || state_reg == ERR);
    assign byte_valid = accept && (state_reg == DATA);
    assign len_full   = {len_hi_reg, bs.in_data};
    assign last_word  = (word_idx_reg == len_reg - 16'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_reg;

    always_ff @(posedge clk) begin
        if (reset || start_load) begin
            csum_reg <= 8'd0;
        end else if (byte_valid) begin
            csum_reg <= csum_reg ^ bs.in_data;
        end
    end
`endif

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_load),
        .byte_valid (byte_valid),
        .byte_data  (bs.in_data),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            len_hi_reg    <= 8'd0;
            len_reg       <= 16'd0;
            word_idx_reg  <= 16'd0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 32'd0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= word_valid;
            if (start_load) word_idx_reg <= 16'd0;
            if (state_reg == LEN_HI && accept) len_hi_reg <= bs.in_data;
            if (state_reg == LEN_LO && accept) len_reg <= len_full;
            // Word k is written the cycle after its last byte, overlapping word k+1 reception.
            if (word_valid) begin
                mem_addr_reg  <= word_idx_reg[ADDR_W-1:0];
                mem_wdata_reg <= packed_word;
                word_idx_reg  <= word_idx_reg + 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: if (start) state_next = LEN_HI;
            LEN_HI:          if (accept) state_next = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DONE;
`endif
                    end else if ({1'b0, len_full} > DEPTH_LIMIT) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: if (accept) state_next = (bs.in_data == csum_reg) ? DONE : ERR;
`endif
            default: state_next = IDLE;
        endcase
    end

    assign bs.in_ready = is_active(state_reg);
    assign busy        = is_active(state_reg);
    assign done        = (state_reg == DONE);
    assign err         = (state_reg == ERR);
    assign cpu_reset   = (state_reg != DONE);
    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus reset/checksum corner sequences.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int MEM_DEPTH = 1024;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader_if bif ();

    imem_loader #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bs        (bif),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          gaps;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    vec_t        vecs[5];
    logic [31:0] fw[4];
    int          vec_cnt  = 0;
    int          miss_cnt = 0;
    int          wr_cnt   = 0;
    int          wr0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            $display("write addr=%0d data=%h", mem_addr, mem_wdata);
            if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL unexpected_write: got addr %0d data %h want none", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check_word("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check_word("wr_data", mem_wdata, mon_e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) begin
            bif.in_valid = 1'b0;
            @(negedge clk);
            if (busy === 1'b1) check_bit("in_ready_gap", bif.in_ready, 1'b1);
        end
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        check_bit("in_ready", bif.in_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_bit("start_busy", busy, 1'b1);
        check_bit("start_cpu_reset", cpu_reset, 1'b1);
        check_bit("start_done", done, 1'b0);
        check_bit("start_err", err, 1'b0);
    endtask

    // Sends words fw[0..nw-1]; expected writes are queued as each word is driven.
    task automatic send_words(input int nw, input int first, input int nbytes, input bit gaps,
                              inout logic [7:0] cs);
        logic [7:0] b;
        for (int k = 0; k < nbytes; k++) begin
            int w = first + k / 4;
            int j = k % 4;
            b = fw[w][31 - 8 * j -: 8];
            cs = cs ^ b;
            if (j == 0 && w < nw) exp_q.push_back('{addr: ADDR_W'(w), data: fw[w]});
            send_byte(b, gaps);
        end
    endtask

    task automatic send_frame(input logic [15:0] len, input int nw, input bit gaps,
                              input logic [7:0] cs_flip);
        logic [7:0] cs = 8'h00;
        send_byte(len[15:8], gaps);
        send_byte(len[7:0], gaps);
        if (32'(len) <= MEM_DEPTH) begin
            send_words(nw, 0, 4 * nw, gaps, cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(cs ^ cs_flip, gaps);
`endif
        end
        bif.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs;

        vecs[0] = '{len: 16'd2,    nw: 2, w0: 32'h20080008, w1: 32'h20090007, gaps: 0, exp_done: 1, exp_err: 0};
        vecs[1] = '{len: 16'd2,    nw: 2, w0: 32'h20080008, w1: 32'h20090007, gaps: 1, exp_done: 1, exp_err: 0};
        vecs[2] = '{len: 16'd0,    nw: 0, w0: 32'h0,        w1: 32'h0,        gaps: 0, exp_done: 1, exp_err: 0};
        vecs[3] = '{len: 16'd1025, nw: 0, w0: 32'h0,        w1: 32'h0,        gaps: 0, exp_done: 0, exp_err: 1};
        vecs[4] = '{len: 16'd1,    nw: 1, w0: 32'h12345678, w1: 32'h0,        gaps: 1, exp_done: 1, exp_err: 0};

        reset        = 1'b1;
        start        = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_bit("rst_in_ready", bif.in_ready, 1'b0);
        check_bit("rst_mem_we", mem_we, 1'b0);
        check_bit("rst_cpu_reset", cpu_reset, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_word("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_word("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            fw[0] = vecs[i].w0;
            fw[1] = vecs[i].w1;
            wr0 = wr_cnt;
            do_start();
            send_frame(vecs[i].len, vecs[i].nw, vecs[i].gaps, 8'h00);
            check_bit("end_done", done, vecs[i].exp_done);
            check_bit("end_err", err, vecs[i].exp_err);
            check_bit("end_cpu_reset", cpu_reset, !vecs[i].exp_done);
            check_bit("end_busy", busy, 1'b0);
            check_bit("end_in_ready", bif.in_ready, 1'b0);
            repeat (4) @(negedge clk);
            check_word("write_count", 32'(wr_cnt - wr0), 32'(vecs[i].nw));
            check_word("queue_left", 32'(exp_q.size()), 32'd0);
            check_bit("sticky_done", done, vecs[i].exp_done);
            $display("frame %0d len=%0d gaps=%0d done=%b err=%b writes=%0d",
                     i, vecs[i].len, vecs[i].gaps, done, err, wr_cnt - wr0);
        end

        // Reset after 6 data bytes: word 0 is written, the partial word 1 is dropped.
        fw[0] = 32'h20080008;
        fw[1] = 32'h20090007;
        wr0 = wr_cnt;
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        cs = 8'h00;
        send_words(1, 0, 6, 0, cs);
        bif.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_bit("abort_in_ready", bif.in_ready, 1'b0);
        check_bit("abort_mem_we", mem_we, 1'b0);
        check_bit("abort_cpu_reset", cpu_reset, 1'b1);
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check_word("abort_mem_addr", 32'(mem_addr), 32'd0);
        check_word("abort_mem_wdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        check_word("abort_write_count", 32'(wr_cnt - wr0), 32'd1);
        check_word("abort_queue_left", 32'(exp_q.size()), 32'd0);
        $display("frame abort writes=%0d", wr_cnt - wr0);

        wr0 = wr_cnt;
        do_start();
        send_frame(16'd2, 2, 0, 8'h00);
        repeat (3) @(negedge clk);
        check_bit("reload_done", done, 1'b1);
        check_bit("reload_cpu_reset", cpu_reset, 1'b0);
        check_word("reload_write_count", 32'(wr_cnt - wr0), 32'd2);
        $display("frame reload done=%b writes=%0d", done, wr_cnt - wr0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // DE^AD^BE^EF = 22: the correct byte loads, 23 aborts after the write.
        fw[0] = 32'hDEADBEEF;
        do_start();
        send_frame(16'd1, 1, 0, 8'h00);
        check_bit("csum_ok_done", done, 1'b1);
        check_bit("csum_ok_err", err, 1'b0);
        $display("frame csum_ok done=%b err=%b", done, err);
        do_start();
        send_frame(16'd1, 1, 0, 8'h01);
        check_bit("csum_bad_err", err, 1'b1);
        check_bit("csum_bad_done", done, 1'b0);
        check_bit("csum_bad_cpu_reset", cpu_reset, 1'b1);
        repeat (2) @(negedge clk);
        check_word("csum_queue_left", 32'(exp_q.size()), 32'd0);
        $display("frame csum_bad done=%b err=%b", done, err);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
